// File: rtl/lc4_free_list_ram.sv
// Tag storage for the free list: d entries of w bits, one asynchronous read
// port, one synchronous write port. Reset reloads entry i with tag n+i.
module lc4_free_list_ram #(
  parameter int n  = 8,
  parameter int w  = 4,
  parameter int d  = 8,
  parameter int aw = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gwe,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [w-1:0]  wdata,
  input  logic [aw-1:0] raddr,
  output logic [w-1:0]  rdata
);

  logic [w-1:0] mem [d];

  // Reset image load, or one write of a returned tag.
  // NOTE: this array is reset on purpose. The reset image is the initial
  // pool of free tags, so the contents are real state, not scratch data.
  always_ff @(posedge clk) begin
    if (gwe) begin
      if (rst) begin
        for (int i = 0; i < d; i++) begin
          mem[i] <= w'(n + i);
        end
      end else if (we) begin
        mem[waddr] <= wdata;
      end
    end
  end

  // Asynchronous read of the entry at the alloc head.
  assign rdata = mem[raddr];

endmodule

// File: rtl/lc4_free_list.sv
// Physical-register free list for the LC4 out-of-order core. A circular
// buffer of tags with three pointers: alloc head (speculative), commit head
// and tail. Entries commit_ptr..alloc_ptr-1 are allocated but uncommitted;
// entries alloc_ptr..tail_ptr-1 are available. A flush moves alloc_ptr back
// to commit_ptr, returning every uncommitted tag in one cycle.
module lc4_free_list #(
  parameter int n = 8,
  parameter int w = 4,
  parameter int p = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic         flush,
  input  logic         alloc,
  output logic [w-1:0] alloc_psel,
  output logic         empty,
  input  logic         commit,
  input  logic         free_we,
  input  logic [w-1:0] free_psel,
  output logic [w:0]   avail,
  output logic [w:0]   inflight
);

  localparam int d  = p - n;
  localparam int aw = (d > 1) ? $clog2(d) : 1;

  // Advance a buffer pointer, wrapping from d-1 to 0 (d need not be 2^k).
  function automatic logic [aw-1:0] ptr_inc(input logic [aw-1:0] ptr);
    return (ptr == aw'(d - 1)) ? '0 : ptr + aw'(1);
  endfunction

  logic [aw-1:0] alloc_ptr, commit_ptr, tail_ptr;
  logic [aw-1:0] alloc_ptr_nx, commit_ptr_nx, tail_ptr_nx;
  logic [w:0]    avail_nx, inflight_nx;
  logic          free_eff, commit_eff, alloc_eff;
  logic [w+1:0]  occupied;

  lc4_free_list_ram #(
    .n  (n),
    .w  (w),
    .d  (d),
    .aw (aw)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .gwe   (gwe),
    .we    (free_eff),
    .waddr (tail_ptr),
    .wdata (free_psel),
    .raddr (alloc_ptr),
    .rdata (alloc_psel)
  );

  assign empty = (avail == '0);

  // Effectiveness is judged on pre-edge state; then next pointers/counters.
  // NOTE: every signal gets a default at the top of this block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    occupied   = {1'b0, avail} + {1'b0, inflight};
    free_eff   = free_we && (occupied < (w+2)'(d));
    commit_eff = commit && (inflight != '0);
    alloc_eff  = alloc && !empty && !flush;

    tail_ptr_nx   = tail_ptr;
    commit_ptr_nx = commit_ptr;
    alloc_ptr_nx  = alloc_ptr;
    avail_nx      = avail;
    inflight_nx   = inflight;

    if (free_eff) tail_ptr_nx = ptr_inc(tail_ptr);
    if (commit_eff) commit_ptr_nx = ptr_inc(commit_ptr);

    if (flush) begin
      // Uncommitted tags (minus one just committed) rejoin the pool.
      alloc_ptr_nx = commit_ptr_nx;
      avail_nx     = avail + inflight + (w+1)'(free_eff) - (w+1)'(commit_eff);
      inflight_nx  = '0;
    end else begin
      if (alloc_eff) alloc_ptr_nx = ptr_inc(alloc_ptr);
      avail_nx    = avail + (w+1)'(free_eff) - (w+1)'(alloc_eff);
      inflight_nx = inflight + (w+1)'(alloc_eff) - (w+1)'(commit_eff);
    end
  end

  // State register: gwe qualifies everything, rst wins over all other inputs.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (gwe) begin
      if (rst) begin
        alloc_ptr  <= '0;
        commit_ptr <= '0;
        tail_ptr   <= '0;
        avail      <= (w+1)'(d);
        inflight   <= '0;
      end else begin
        alloc_ptr  <= alloc_ptr_nx;
        commit_ptr <= commit_ptr_nx;
        tail_ptr   <= tail_ptr_nx;
        avail      <= avail_nx;
        inflight   <= inflight_nx;
      end
    end
  end

endmodule

// File: tb/tb_lc4_free_list.sv
// Self-checking bench for lc4_free_list. The reference model keeps two
// queues of tags: the available pool (front = next to allocate) and the
// outstanding allocations (front = oldest).
module tb_lc4_free_list;

  localparam int N = 8;
  localparam int W = 4;
  localparam int P = 16;
  localparam int D = P - N;

  logic         clk = 1'b0;
  logic         rst, gwe, flush, alloc, commit, free_we;
  logic [W-1:0] free_psel;
  logic [W-1:0] alloc_psel;
  logic         empty;
  logic [W:0]   avail, inflight;

  int n_checks = 0;
  int n_pass   = 0;

  int pool_q[$];
  int spec_q[$];

  lc4_free_list #(.n(N), .w(W), .p(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .gwe        (gwe),
    .flush      (flush),
    .alloc      (alloc),
    .alloc_psel (alloc_psel),
    .empty      (empty),
    .commit     (commit),
    .free_we    (free_we),
    .free_psel  (free_psel),
    .avail      (avail),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  function automatic void model_reset();
    pool_q.delete();
    spec_q.delete();
    for (int i = 0; i < D; i++) pool_q.push_back(N + i);
  endfunction

  function automatic void model_step(input bit f, input bit a, input bit c,
                                     input bit fw, input int fp);
    bit free_ok, commit_ok, alloc_ok;
    free_ok   = fw && (pool_q.size() + spec_q.size() < D);
    commit_ok = c && (spec_q.size() != 0);
    alloc_ok  = a && (pool_q.size() != 0) && !f;
    if (free_ok) pool_q.push_back(fp);
    if (commit_ok) void'(spec_q.pop_front());
    if (f) begin
      for (int i = spec_q.size() - 1; i >= 0; i--) pool_q.push_front(spec_q[i]);
      spec_q.delete();
    end else if (alloc_ok) begin
      spec_q.push_back(pool_q.pop_front());
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".avail"}, int'(avail), pool_q.size());
    check({tag, ".inflight"}, int'(inflight), spec_q.size());
    check({tag, ".empty"}, int'(empty), int'(pool_q.size() == 0));
    if (pool_q.size() != 0) check({tag, ".alloc_psel"}, int'(alloc_psel), pool_q[0]);
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic cycle(input string tag, input bit g, input bit r, input bit f,
                       input bit a, input bit c, input bit fw, input int fp);
    gwe = g; rst = r; flush = f; alloc = a; commit = c; free_we = fw;
    free_psel = W'(fp);
    @(posedge clk);
    if (g) begin
      if (r) model_reset();
      else model_step(f, a, c, fw, fp);
    end
    @(negedge clk);
    gwe = 1'b1; rst = 1'b0; flush = 1'b0; alloc = 1'b0; commit = 1'b0; free_we = 1'b0;
    compare_all(tag);
  endtask

  task automatic do_reset();
    cycle("reset", 1, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    gwe = 1'b1; rst = 1'b1; flush = 1'b0; alloc = 1'b0; commit = 1'b0;
    free_we = 1'b0; free_psel = '0;
    @(negedge clk);
    do_reset();
    check("rst.avail", int'(avail), 8);
    check("rst.inflight", int'(inflight), 0);
    check("rst.empty", int'(empty), 0);
    check("rst.psel", int'(alloc_psel), 8);

    // Drain the pool: tags come out 8..15, then empty.
    for (int k = 0; k < D; k++) begin
      check("t1.seq", int'(alloc_psel), N + k);
      cycle("t1", 1, 0, 0, 1, 0, 0, 0);
    end
    check("t1.empty", int'(empty), 1);
    check("t1.avail", int'(avail), 0);
    check("t1.inflight", int'(inflight), 8);

    // Commit everything so a free is accepted, then alloc+free while empty.
    for (int k = 0; k < D; k++) cycle("t2.commit", 1, 0, 0, 0, 1, 0, 0);
    cycle("t2", 1, 0, 0, 1, 0, 1, 3);
    check("t2.empty", int'(empty), 0);
    check("t2.psel", int'(alloc_psel), 3);
    check("t2.avail", int'(avail), 1);
    check("t2.inflight", int'(inflight), 0);

    // Three allocs, one commit, flush: tags 9 and 10 return to the pool.
    do_reset();
    for (int k = 0; k < 3; k++) cycle("t3.alloc", 1, 0, 0, 1, 0, 0, 0);
    cycle("t3.commit", 1, 0, 0, 0, 1, 0, 0);
    cycle("t3.flush", 1, 0, 1, 0, 0, 0, 0);
    check("t3.avail", int'(avail), 7);
    check("t3.inflight", int'(inflight), 0);
    check("t3.psel", int'(alloc_psel), 9);

    // Flush + commit + alloc with inflight=2, avail=6: tag 8 commits,
    // tag 9 returns, so avail = 6 + 2 - 1.
    do_reset();
    cycle("t4.alloc", 1, 0, 0, 1, 0, 0, 0);
    cycle("t4.alloc", 1, 0, 0, 1, 0, 0, 0);
    cycle("t4.flush", 1, 0, 1, 1, 1, 0, 0);
    check("t4.avail", int'(avail), 7);
    check("t4.inflight", int'(inflight), 0);
    check("t4.psel", int'(alloc_psel), 9);

    // Overflowing free and commit with nothing inflight are both ignored.
    do_reset();
    cycle("t5.free", 1, 0, 0, 0, 0, 1, 5);
    check("t5.avail", int'(avail), 8);
    cycle("t5.commit", 1, 0, 0, 0, 1, 0, 0);
    check("t5.inflight", int'(inflight), 0);

    // gwe low freezes everything, then reset mid-sequence.
    cycle("t6.alloc", 1, 0, 0, 1, 0, 0, 0);
    cycle("t6.alloc", 1, 0, 0, 1, 0, 0, 0);
    cycle("t6.hold", 0, 1, 1, 1, 1, 1, 2);
    check("t6.hold.avail", int'(avail), 6);
    check("t6.hold.psel", int'(alloc_psel), 10);
    do_reset();
    check("t6.rst.avail", int'(avail), 8);
    check("t6.rst.psel", int'(alloc_psel), 8);

    // Randomized traffic against the queue model.
    for (int k = 0; k < 3000; k++) begin
      bit g, r, f, a, c, fw;
      g  = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 15) == 0);
      a  = ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 2) == 0);
      fw = ($urandom_range(0, 2) == 0);
      cycle("rand", g, r, f, a, c, fw, int'($urandom_range(0, P - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
